// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, defaults and
// bit positions of the stage-control bundle {pc,ifid,idex,exmem,memwb}.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_MEMWAIT   = 3'd1,
        ST_IRQ_DRAIN = 3'd2,
        ST_IRQ_ENTER = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    localparam int unsigned STG_PC    = 4;
    localparam int unsigned STG_IFID  = 3;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 1;
    localparam int unsigned STG_MEMWB = 0;

    typedef logic [4:0] stage_vec_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes, memory freezes, interrupt drain/entry
// and syscall halt, plus saturating event counters for the debug display.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned REG_AW       = REG_AW_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [REG_AW-1:0]    idRs,
    input  logic [REG_AW-1:0]    idRt,
    input  logic                 idUsesRs,
    input  logic                 idUsesRt,
    input  logic                 exMemRead,
    input  logic                 exRegWrite,
    input  logic [REG_AW-1:0]    exRd,
    input  logic                 branchTaken,
    input  logic                 haltReq,
    input  logic                 resume,
    input  logic                 memReq,
    input  logic                 memReady,
    input  logic                 irqPending,
    output logic                 pcEnable,
    output logic                 pcSelVector,
    output logic                 ifidEn,
    output logic                 ifidClr,
    output logic                 idexEn,
    output logic                 idexClr,
    output logic                 exmemEn,
    output logic                 exmemClr,
    output logic                 memwbEn,
    output logic                 memwbClr,
    output logic                 irqAck,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cntLoadUse,
    output logic [CNT_WIDTH-1:0] cntFlush,
    output logic [CNT_WIDTH-1:0] cntMemWait
);

    localparam int unsigned   DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    stage_vec_t    en, clr;
    logic          inc_lu, inc_fl, inc_mw;
    logic          mem_stall, load_use;

    assign mem_stall = memReq & ~memReady;
    assign load_use  = exMemRead & exRegWrite & (exRd != '0) &
                       ((idUsesRs & (idRs == exRd)) | (idUsesRt & (idRt == exRd)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        en          = '1;
        clr         = '0;
        pcSelVector = 1'b0;
        irqAck      = 1'b0;
        halted      = 1'b0;
        inc_lu      = 1'b0;
        inc_fl      = 1'b0;
        inc_mw      = 1'b0;
        unique case (state)
            // MEMWAIT shares the RUN priority chain once memory is ready
            ST_RUN, ST_MEMWAIT: begin
                if ((state == ST_MEMWAIT) ? !memReady : mem_stall) begin
                    en        = '0;
                    inc_mw    = 1'b1;
                    state_nxt = ST_MEMWAIT;
                end else begin
                    state_nxt = ST_RUN;
                    if (branchTaken) begin
                        clr[STG_IFID] = 1'b1;
                        clr[STG_IDEX] = 1'b1;
                        inc_fl        = 1'b1;
                    end else if (haltReq) begin
                        en[STG_PC]    = 1'b0;
                        clr[STG_IFID] = 1'b1;
                        state_nxt     = ST_HALTED;
                    end else if (load_use) begin
                        en[STG_PC]    = 1'b0;
                        en[STG_IFID]  = 1'b0;
                        clr[STG_IDEX] = 1'b1;
                        inc_lu        = 1'b1;
                    end else if (irqPending) begin
                        en[STG_PC]    = 1'b0;
                        clr[STG_IFID] = 1'b1;
                        drain_nxt     = DRAIN_LOAD;
                        state_nxt     = (DRAIN_CYCLES > 1) ? ST_IRQ_DRAIN : ST_IRQ_ENTER;
                    end
                end
            end
            // The detecting RUN cycle is the first drain cycle, so the count runs DRAIN_CYCLES-1 .. 1
            ST_IRQ_DRAIN: begin
                if (mem_stall) begin
                    en     = '0;
                    inc_mw = 1'b1;
                end else begin
                    en[STG_PC]    = 1'b0;
                    clr[STG_IFID] = 1'b1;
                    if (branchTaken) begin
                        clr[STG_IDEX] = 1'b1;
                        inc_fl        = 1'b1;
                    end
                    drain_nxt = drain_cnt - DW'(1);
                    if (drain_cnt <= DW'(1)) begin
                        state_nxt = ST_IRQ_ENTER;
                    end
                end
            end
            ST_IRQ_ENTER: begin
                pcSelVector   = 1'b1;
                irqAck        = 1'b1;
                clr[STG_IFID] = 1'b1;
                state_nxt     = ST_RUN;
            end
            ST_HALTED: begin
                en[STG_PC]    = 1'b0;
                clr[STG_IFID] = 1'b1;
                halted        = 1'b1;
                if (resume) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign pcEnable = en[STG_PC];
    assign ifidEn   = en[STG_IFID];
    assign idexEn   = en[STG_IDEX];
    assign exmemEn  = en[STG_EXMEM];
    assign memwbEn  = en[STG_MEMWB];
    assign ifidClr  = clr[STG_IFID]  & en[STG_IFID];
    assign idexClr  = clr[STG_IDEX]  & en[STG_IDEX];
    assign exmemClr = clr[STG_EXMEM] & en[STG_EXMEM];
    assign memwbClr = clr[STG_MEMWB] & en[STG_MEMWB];

    sat_counter #(.W(CNT_WIDTH)) u_cnt_load_use (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (inc_lu),
        .value  (cntLoadUse)
    );

    sat_counter #(.W(CNT_WIDTH)) u_cnt_flush (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (inc_fl),
        .value  (cntFlush)
    );

    sat_counter #(.W(CNT_WIDTH)) u_cnt_mem_wait (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (inc_mw),
        .value  (cntMemWait)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: action-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] idRs, idRt, exRd;
    logic       idUsesRs, idUsesRt, exMemRead, exRegWrite;
    logic       branchTaken, haltReq, resume, memReq, memReady, irqPending;

    logic        pcEnable, pcSelVector, ifidEn, ifidClr, idexEn, idexClr;
    logic        exmemEn, exmemClr, memwbEn, memwbClr, irqAck, halted;
    logic [31:0] cntLoadUse, cntFlush, cntMemWait;

    logic        s_pcEnable, s_pcSelVector, s_ifidEn, s_ifidClr, s_idexEn, s_idexClr;
    logic        s_exmemEn, s_exmemClr, s_memwbEn, s_memwbClr, s_irqAck, s_halted;
    logic [2:0]  s_cntLoadUse, s_cntFlush, s_cntMemWait;

    logic [11:0] act_vec, s_vec;
    assign act_vec = {pcEnable, pcSelVector, ifidEn, ifidClr, idexEn, idexClr,
                      exmemEn, exmemClr, memwbEn, memwbClr, irqAck, halted};
    assign s_vec   = {s_pcEnable, s_pcSelVector, s_ifidEn, s_ifidClr, s_idexEn, s_idexClr,
                      s_exmemEn, s_exmemClr, s_memwbEn, s_memwbClr, s_irqAck, s_halted};

    // Output patterns {pc,sel,ifidEn,ifidClr,idexEn,idexClr,exmemEn,exmemClr,memwbEn,memwbClr,ack,halted}
    localparam logic [11:0] V_RUN    = 12'b1010_1010_1000;
    localparam logic [11:0] V_FREEZE = 12'b0000_0000_0000;
    localparam logic [11:0] V_FLUSH  = 12'b1011_1110_1000;
    localparam logic [11:0] V_DRAIN  = 12'b0011_1010_1000;
    localparam logic [11:0] V_DRFL   = 12'b0011_1110_1000;
    localparam logic [11:0] V_STALL  = 12'b0000_1110_1000;
    localparam logic [11:0] V_VECTOR = 12'b1111_1010_1010;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset_n(reset_n), .idRs(idRs), .idRt(idRt),
        .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .exMemRead(exMemRead),
        .exRegWrite(exRegWrite), .exRd(exRd), .branchTaken(branchTaken),
        .haltReq(haltReq), .resume(resume), .memReq(memReq), .memReady(memReady),
        .irqPending(irqPending), .pcEnable(pcEnable), .pcSelVector(pcSelVector),
        .ifidEn(ifidEn), .ifidClr(ifidClr), .idexEn(idexEn), .idexClr(idexClr),
        .exmemEn(exmemEn), .exmemClr(exmemClr), .memwbEn(memwbEn), .memwbClr(memwbClr),
        .irqAck(irqAck), .halted(halted), .cntLoadUse(cntLoadUse),
        .cntFlush(cntFlush), .cntMemWait(cntMemWait)
    );

    pipe_hazard_ctrl #(.CNT_WIDTH(3)) dut_s (
        .clock(clock), .reset_n(reset_n), .idRs(idRs), .idRt(idRt),
        .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .exMemRead(exMemRead),
        .exRegWrite(exRegWrite), .exRd(exRd), .branchTaken(branchTaken),
        .haltReq(haltReq), .resume(resume), .memReq(memReq), .memReady(memReady),
        .irqPending(irqPending), .pcEnable(s_pcEnable), .pcSelVector(s_pcSelVector),
        .ifidEn(s_ifidEn), .ifidClr(s_ifidClr), .idexEn(s_idexEn), .idexClr(s_idexClr),
        .exmemEn(s_exmemEn), .exmemClr(s_exmemClr), .memwbEn(s_memwbEn), .memwbClr(s_memwbClr),
        .irqAck(s_irqAck), .halted(s_halted), .cntLoadUse(s_cntLoadUse),
        .cntFlush(s_cntFlush), .cntMemWait(s_cntMemWait)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pipeline is in one of a few modes, and each cycle
    // reduces to one named action that fixes the whole output pattern.
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_ENTER = 3, M_HALT = 4;
    localparam longint MAX_BIG = 64'hFFFF_FFFF;
    localparam longint MAX_SMALL = 7;

    int     m_mode = M_RUN;
    int     m_left = 0;
    longint m_lu = 0, m_fl = 0, m_mw = 0;
    longint s_lu = 0, s_fl = 0, s_mw = 0;

    function automatic longint sat_inc(longint v, longint max);
        return (v >= max) ? max : v + 1;
    endfunction

    always @(negedge clock) begin : compare
        logic [11:0] exp_v;
        int          nmode;
        int          ev;
        bit          lu;
        if (!reset_n) begin
            m_mode = M_RUN; m_left = 0;
            m_lu = 0; m_fl = 0; m_mw = 0;
            s_lu = 0; s_fl = 0; s_mw = 0;
        end else begin
            lu = exMemRead && exRegWrite && (exRd != 0) &&
                 ((idUsesRs && idRs == exRd) || (idUsesRt && idRt == exRd));
            nmode = m_mode;
            ev    = 0;
            exp_v = V_RUN;
            if (m_mode == M_HALT) begin
                exp_v = V_DRAIN | 12'd1;
                if (resume) nmode = M_RUN;
            end else if (m_mode == M_ENTER) begin
                exp_v = V_VECTOR;
                nmode = M_RUN;
            end else if (m_mode == M_DRAIN) begin
                if (memReq && !memReady) begin
                    exp_v = V_FREEZE; ev = 3;
                end else begin
                    exp_v = branchTaken ? V_DRFL : V_DRAIN;
                    if (branchTaken) ev = 2;
                    m_left = m_left - 1;
                    if (m_left == 0) nmode = M_ENTER;
                end
            end else if ((m_mode == M_WAIT) ? !memReady : (memReq && !memReady)) begin
                exp_v = V_FREEZE; ev = 3; nmode = M_WAIT;
            end else begin
                nmode = M_RUN;
                if (branchTaken) begin
                    exp_v = V_FLUSH; ev = 2;
                end else if (haltReq) begin
                    exp_v = V_DRAIN; nmode = M_HALT;
                end else if (lu) begin
                    exp_v = V_STALL; ev = 1;
                end else if (irqPending) begin
                    exp_v = V_DRAIN; nmode = M_DRAIN; m_left = 2;
                end
            end
            check("outputs", act_vec, exp_v);
            check("outputs_w3", s_vec, exp_v);
            check("cntLoadUse", cntLoadUse, m_lu);
            check("cntFlush", cntFlush, m_fl);
            check("cntMemWait", cntMemWait, m_mw);
            check("cntLoadUse_w3", s_cntLoadUse, s_lu);
            check("cntFlush_w3", s_cntFlush, s_fl);
            check("cntMemWait_w3", s_cntMemWait, s_mw);
            if (ev == 1) begin m_lu = sat_inc(m_lu, MAX_BIG); s_lu = sat_inc(s_lu, MAX_SMALL); end
            if (ev == 2) begin m_fl = sat_inc(m_fl, MAX_BIG); s_fl = sat_inc(s_fl, MAX_SMALL); end
            if (ev == 3) begin m_mw = sat_inc(m_mw, MAX_BIG); s_mw = sat_inc(s_mw, MAX_SMALL); end
            m_mode = nmode;
        end
    end

    task automatic idle();
        idRs = '0; idRt = '0; exRd = '0;
        idUsesRs = 0; idUsesRt = 0; exMemRead = 0; exRegWrite = 0;
        branchTaken = 0; haltReq = 0; resume = 0;
        memReq = 0; memReady = 0; irqPending = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_load_use(logic [4:0] rd);
        exMemRead = 1; exRegWrite = 1; exRd = rd; idRs = rd; idUsesRs = 1;
    endtask

    initial begin
        int  nd;
        bit  seen;
        logic [11:0] ackv;

        idle();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        #2;
        check("reset_outputs", act_vec, V_RUN);
        check("reset_cntLoadUse", cntLoadUse, 0);
        check("reset_cntFlush", cntFlush, 0);
        check("reset_cntMemWait", cntMemWait, 0);

        // Load-use stall, exactly one cycle
        tick(); set_load_use(5'd5); #2;
        check("lu_stall", act_vec, V_STALL);
        tick(); idle(); #2;
        check("lu_one_cycle", act_vec, V_RUN);
        check("lu_count", cntLoadUse, 1);

        // Destination r0 never stalls; branch beats load-use
        tick(); set_load_use(5'd0); #2;
        check("lu_r0_run", act_vec, V_RUN);
        tick(); idle(); set_load_use(5'd5); branchTaken = 1; #2;
        check("lu_r0_count", cntLoadUse, 1);
        check("flush_wins", act_vec, V_FLUSH);
        tick(); idle(); #2;
        check("flush_count", cntFlush, 1);
        check("flush_lu_count", cntLoadUse, 1);

        // Four-cycle memory freeze
        tick(); memReq = 1; memReady = 0; #2;
        check("memwait_freeze", act_vec, V_FREEZE);
        repeat (3) begin
            tick(); #2;
            check("memwait_freeze", act_vec, V_FREEZE);
        end
        tick(); memReady = 1; #2;
        check("memwait_ready", act_vec, V_RUN);
        tick(); idle(); #2;
        check("memwait_count", cntMemWait, 4);

        // Interrupt drain then entry
        tick(); irqPending = 1; #2;
        check("irq_first_drain", act_vec, V_DRAIN);
        nd = 1; seen = 0; ackv = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(); irqPending = 0; #2;
            if (irqAck) begin
                seen = 1; ackv = act_vec;
            end else if (act_vec == V_DRAIN) begin
                nd++;
            end
        end
        check("irq_ack_seen", seen, 1);
        check("irq_drain_cycles", nd, 3);
        check("irq_enter", ackv, V_VECTOR);
        tick(); #2;
        check("irq_back_to_run", act_vec, V_RUN);

        // Halt holds PC and ignores interrupts until resume
        tick(); haltReq = 1; #2;
        check("halt_entry", act_vec, V_DRAIN);
        tick(); haltReq = 0; irqPending = 1;
        for (int i = 0; i < 10; i++) begin
            #2;
            check("halt_hold", act_vec, V_DRAIN | 12'd1);
            tick();
        end
        resume = 1; #2;
        check("halt_resume_cycle", act_vec, V_DRAIN | 12'd1);
        tick(); resume = 0; irqPending = 0; #2;
        check("halt_released", act_vec, V_RUN);

        // Asynchronous reset while draining
        tick(); irqPending = 1;
        tick(); irqPending = 0; #2;
        check("drain_before_reset", act_vec, V_DRAIN);
        reset_n = 0; #1;
        check("async_reset_outputs", act_vec, V_RUN);
        check("async_reset_cntLoadUse", cntLoadUse, 0);
        check("async_reset_cntFlush", cntFlush, 0);
        check("async_reset_cntMemWait", cntMemWait, 0);
        tick(); tick(); reset_n = 1;

        // Saturation on the 3-bit instance
        repeat (9) begin
            tick(); branchTaken = 1;
        end
        tick(); idle(); #2;
        check("sat_flush_w3", s_cntFlush, 7);
        check("sat_flush_w32", cntFlush, 9);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            idRs        = 5'($urandom_range(0, 3));
            idRt        = 5'($urandom_range(0, 3));
            exRd        = 5'($urandom_range(0, 3));
            idUsesRs    = 1'($urandom_range(0, 1));
            idUsesRt    = 1'($urandom_range(0, 1));
            exMemRead   = 1'($urandom_range(0, 1));
            exRegWrite  = 1'($urandom_range(0, 1));
            branchTaken = ($urandom_range(0, 7) == 0);
            haltReq     = ($urandom_range(0, 39) == 0);
            resume      = ($urandom_range(0, 7) == 0);
            memReq      = ($urandom_range(0, 3) == 0);
            memReady    = 1'($urandom_range(0, 1));
            irqPending  = ($urandom_range(0, 19) == 0);
        end
        tick(); idle(); #2;
        tick(); #6;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
